// File: rtl/ring_mon_pkg.sv
// ring_mon_pkg: shared types and constants for the ring phase monitor.
// Contents: FSM state enum, default ring/rotation-counter widths,
//           and a width-generic rotate_left helper.
package ring_mon_pkg;

    typedef enum logic [1:0] {
        SYNC  = 2'd0,
        TRACK = 2'd1,
        FAULT = 2'd2
    } state_e;

    localparam int RING_WIDTH_DEF = 3;
    localparam int ROT_W_DEF      = 8;
    // Widest ring the rotate helper supports.
    localparam int RING_MAX_W     = 32;

    // Rotate the low w bits of v left by one (bit w-1 wraps to bit 0).
    // Bits at or above w are returned as zero.
    function automatic logic [RING_MAX_W-1:0] rotate_left(
        input logic [RING_MAX_W-1:0] v,
        input int                    w
    );
        logic [RING_MAX_W-1:0] r;
        r    = v << 1;
        r[0] = v[w-1];
        r    = r & ~({RING_MAX_W{1'b1}} << w);
        return r;
    endfunction

endpackage

// File: rtl/ring_phase_monitor_if.sv
// ring_phase_monitor_if: bundles the ring sample input and monitor status outputs.
// master: the ring source / status consumer (drives ring_q, clr_err).
// slave : the monitor (drives phase, phase_vld, wrap_pulse, rot_count, err_*).
interface ring_phase_monitor_if
    import ring_mon_pkg::*;
#(
    parameter int WIDTH = RING_WIDTH_DEF,
    parameter int PH_W  = $clog2(WIDTH),
    parameter int ROT_W = ROT_W_DEF
);
    logic [WIDTH-1:0] ring_q;
    logic             clr_err;
    logic [PH_W-1:0]  phase;
    logic             phase_vld;
    logic             wrap_pulse;
    logic [ROT_W-1:0] rot_count;
    logic             err_onehot;
    logic             err_seq;

    modport master (
        output ring_q, clr_err,
        input  phase, phase_vld, wrap_pulse, rot_count, err_onehot, err_seq
    );

    modport slave (
        input  ring_q, clr_err,
        output phase, phase_vld, wrap_pulse, rot_count, err_onehot, err_seq
    );
endinterface

// File: rtl/ring_phase_monitor_onehot_enc.sv
// onehot_enc: combinational one-hot to binary encoder.
// Ports: in_i (one-hot vector), idx_o (OR of set-bit indices, valid when
//        onehot_o), onehot_o (exactly one bit of in_i set).
module onehot_enc #(
    parameter int WIDTH = 3,
    parameter int PH_W  = $clog2(WIDTH)
) (
    input  logic [WIDTH-1:0] in_i,
    output logic [PH_W-1:0]  idx_o,
    output logic             onehot_o
);

    always_comb begin
        idx_o = '0;
        for (int i = 0; i < WIDTH; i++) begin
            if (in_i[i]) begin
                idx_o = idx_o | PH_W'(i);
            end
        end
    end

    // Non-zero with no second bit: clearing the lowest set bit leaves nothing.
    assign onehot_o = (in_i != '0) && ((in_i & (in_i - 1'b1)) == '0);

endmodule

// File: rtl/ring_phase_monitor.sv
// ring_phase_monitor: samples a one-hot ring counter, encodes its phase,
// counts rotations and flags illegal encodings / steps (sticky).
// Ports: clk, rst (async active-low), mon (slave modport: ring_q, clr_err in;
//        phase, phase_vld, wrap_pulse, rot_count, err_onehot, err_seq out).
// Option: RING_MON_HOLD_EN makes a repeated sample legal while tracking.
module ring_phase_monitor
    import ring_mon_pkg::*;
#(
    parameter int WIDTH = RING_WIDTH_DEF,
    parameter int PH_W  = $clog2(WIDTH),
    parameter int ROT_W = ROT_W_DEF
) (
    input  logic                  clk,
    input  logic                  rst,
    ring_phase_monitor_if.slave   mon
);

    state_e           state_q, state_d;
    logic [PH_W-1:0]  phase_q, phase_d;
    logic             vld_q, vld_d;
    logic             wrap_q, wrap_d;
    logic [ROT_W-1:0] rot_q, rot_d;
    logic             eoh_q, eoh_d;
    logic             eseq_q, eseq_d;

    logic [PH_W-1:0]       enc_idx;
    logic                  enc_onehot;
    logic [WIDTH-1:0]      prev_oh;
    logic [RING_MAX_W-1:0] next_oh;
    logic                  step_ok;
    logic                  hold_ok;

    onehot_enc #(.WIDTH(WIDTH), .PH_W(PH_W)) u_enc (
        .in_i     (mon.ring_q),
        .idx_o    (enc_idx),
        .onehot_o (enc_onehot)
    );

    // Expected next sample is the last legal phase rotated by one position.
    always_comb begin
        prev_oh          = '0;
        prev_oh[phase_q] = 1'b1;
        next_oh          = rotate_left(RING_MAX_W'(prev_oh), WIDTH);
        step_ok          = (RING_MAX_W'(mon.ring_q) == next_oh);
    end

`ifdef RING_MON_HOLD_EN
    assign hold_ok = (mon.ring_q == prev_oh);
`else
    assign hold_ok = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        phase_d = phase_q;
        rot_d   = rot_q;
        wrap_d  = 1'b0;
        eoh_d   = eoh_q;
        eseq_d  = eseq_q;

        if (mon.clr_err) begin
            // Clear wins over anything seen this cycle; the sample is dropped.
            state_d = SYNC;
            eoh_d   = 1'b0;
            eseq_d  = 1'b0;
        end else begin
            unique case (state_q)
                SYNC: begin
                    if (enc_onehot) begin
                        phase_d = enc_idx;
                        state_d = TRACK;
                    end
                end
                TRACK: begin
                    if (!enc_onehot) begin
                        eoh_d   = 1'b1;
                        state_d = FAULT;
                    end else if (step_ok) begin
                        phase_d = enc_idx;
                        if (phase_q == PH_W'(WIDTH - 1)) begin
                            wrap_d = 1'b1;
                            rot_d  = rot_q + 1'b1;
                        end
                    end else if (!hold_ok) begin
                        eseq_d  = 1'b1;
                        state_d = FAULT;
                    end
                end
                FAULT: begin
                    state_d = FAULT;
                end
                default: begin
                    state_d = SYNC;
                end
            endcase
        end

        vld_d = (state_d == TRACK);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= SYNC;
            phase_q <= '0;
            vld_q   <= 1'b0;
            wrap_q  <= 1'b0;
            rot_q   <= '0;
            eoh_q   <= 1'b0;
            eseq_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            phase_q <= phase_d;
            vld_q   <= vld_d;
            wrap_q  <= wrap_d;
            rot_q   <= rot_d;
            eoh_q   <= eoh_d;
            eseq_q  <= eseq_d;
        end
    end

    assign mon.phase      = phase_q;
    assign mon.phase_vld  = vld_q;
    assign mon.wrap_pulse = wrap_q;
    assign mon.rot_count  = rot_q;
    assign mon.err_onehot = eoh_q;
    assign mon.err_seq    = eseq_q;

endmodule

// File: tb/tb_ring_phase_monitor.sv
// tb_ring_phase_monitor: directed + randomized bench for ring_phase_monitor
// against a phase-index reference model. Honours RING_MON_HOLD_EN.
module tb_ring_phase_monitor;

    localparam int W  = 3;
    localparam int RW = 8;
    localparam int M_SYNC = 0, M_TRACK = 1, M_FAULT = 2;

    logic clk = 1'b0;
    logic rst;

    ring_phase_monitor_if #(.WIDTH(W), .ROT_W(RW)) mon_if ();

    ring_phase_monitor #(.WIDTH(W), .ROT_W(RW)) dut (
        .clk (clk),
        .rst (rst),
        .mon (mon_if)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int dut_wraps;

    // Reference model state: phase as an integer index.
    int m_state, m_phase, m_rot;
    bit m_vld, m_wrap, m_eoh, m_eseq;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_state = M_SYNC; m_phase = 0; m_rot = 0;
        m_vld = 0; m_wrap = 0; m_eoh = 0; m_eseq = 0;
    endtask

    task automatic model_step(input logic [W-1:0] r, input bit c);
        int ones;
        int idx;
        ones = $countones(r);
        idx  = 0;
        for (int i = 0; i < W; i++) if (r[i]) idx = i;
        m_wrap = 0;
        if (c) begin
            m_state = M_SYNC; m_eoh = 0; m_eseq = 0;
        end else if (m_state == M_SYNC) begin
            if (ones == 1) begin m_phase = idx; m_state = M_TRACK; end
        end else if (m_state == M_TRACK) begin
            if (ones != 1) begin
                m_eoh = 1; m_state = M_FAULT;
            end else if (idx == (m_phase + 1) % W) begin
                if (m_phase == W - 1) begin
                    m_wrap = 1;
                    m_rot  = (m_rot + 1) % (1 << RW);
                end
                m_phase = idx;
            end else begin
`ifdef RING_MON_HOLD_EN
                if (idx != m_phase) begin m_eseq = 1; m_state = M_FAULT; end
`else
                m_eseq = 1; m_state = M_FAULT;
`endif
            end
        end
        m_vld = (m_state == M_TRACK);
    endtask

    task automatic compare_all(input string tag);
        check_val({tag, ".phase"},  32'(mon_if.phase),      32'(m_phase));
        check_val({tag, ".vld"},    32'(mon_if.phase_vld),  32'(m_vld));
        check_val({tag, ".wrap"},   32'(mon_if.wrap_pulse), 32'(m_wrap));
        check_val({tag, ".rot"},    32'(mon_if.rot_count),  32'(m_rot));
        check_val({tag, ".eoh"},    32'(mon_if.err_onehot), 32'(m_eoh));
        check_val({tag, ".eseq"},   32'(mon_if.err_seq),    32'(m_eseq));
    endtask

    // Called at a falling edge: drive, let the rising edge sample, check at next fall.
    task automatic step(input string tag, input logic [W-1:0] r, input bit c = 1'b0);
        mon_if.ring_q  = r;
        mon_if.clr_err = c;
        @(posedge clk);
        model_step(r, c);
        @(negedge clk);
        if (mon_if.wrap_pulse) dut_wraps++;
        compare_all(tag);
    endtask

    task automatic apply_reset();
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        @(negedge clk);
        rst = 1'b1;
    endtask

    initial begin
        logic [W-1:0] r;
        int p;
        rst = 1'b0;
        mon_if.ring_q  = '0;
        mon_if.clr_err = 1'b0;
        model_reset();
        dut_wraps = 0;
        #3;
        compare_all("reset");
        @(negedge clk);
        rst = 1'b1;

        // Basic rotation: phase 0,1,2,0 with one wrap.
        step("rot0", 3'b001);
        step("rot1", 3'b010);
        step("rot2", 3'b100);
        step("rot3", 3'b001);
        check_val("rot.count1", 32'(mon_if.rot_count), 32'd1);

        // Non-one-hot in TRACK, then clear and resync.
        step("oh0", 3'b010);
        step("oh1", 3'b011);
        check_val("oh.err", 32'(mon_if.err_onehot), 32'd1);
        check_val("oh.phase_frozen", 32'(mon_if.phase), 32'd1);
        step("oh2", 3'b100);
        step("ohclr", 3'b000, 1'b1);
        step("ohsync", 3'b100);
        check_val("oh.resync_phase", 32'(mon_if.phase), 32'd2);

        // Reverse step.
        step("rev0", 3'b001);
        step("rev1", 3'b100);
        check_val("rev.eseq", 32'(mon_if.err_seq), 32'd1);
        check_val("rev.eoh", 32'(mon_if.err_onehot), 32'd0);
        check_val("rev.rot", 32'(mon_if.rot_count), 32'd2);
        step("revclr", 3'b001, 1'b1);

        // Held sample.
        step("hold0", 3'b001);
        step("hold1", 3'b010);
        step("hold2", 3'b010);
`ifdef RING_MON_HOLD_EN
        check_val("hold.eseq", 32'(mon_if.err_seq), 32'd0);
        check_val("hold.phase", 32'(mon_if.phase), 32'd1);
`else
        check_val("hold.eseq", 32'(mon_if.err_seq), 32'd1);
`endif
        step("holdclr", 3'b000, 1'b1);

        // Idle all-zero after reset stays in SYNC without errors.
        apply_reset();
        for (int i = 0; i < 5; i++) step("idle", 3'b000);
        check_val("idle.vld", 32'(mon_if.phase_vld), 32'd0);

        // 256 rotations wrap the counter back to zero.
        step("full.sync", 3'b001);
        dut_wraps = 0;
        for (int i = 0; i < 256; i++) begin
            step("full", 3'b010);
            step("full", 3'b100);
            step("full", 3'b001);
        end
        check_val("full.rot", 32'(mon_if.rot_count), 32'd0);
        check_val("full.wraps", 32'(dut_wraps), 32'd256);
        for (int i = 0; i < 2; i++) begin
            step("more", 3'b010);
            step("more", 3'b100);
            step("more", 3'b001);
        end
        step("more", 3'b010);

        // Asynchronous reset mid-rotation, checked before any rising edge.
        #2;
        rst = 1'b0;
        #1;
        model_reset();
        compare_all("areset");
        check_val("areset.rot", 32'(mon_if.rot_count), 32'd0);
        @(negedge clk);
        rst = 1'b1;
        step("post.sync", 3'b100);
        check_val("post.phase", 32'(mon_if.phase), 32'd2);

        // Error and clear in the same cycle: clear wins.
        step("cwin", 3'b011, 1'b1);
        check_val("cwin.eoh", 32'(mon_if.err_onehot), 32'd0);
        check_val("cwin.vld", 32'(mon_if.phase_vld), 32'd0);

        // Randomized traffic biased towards legal rotation.
        for (int i = 0; i < 600; i++) begin
            p = $urandom_range(0, 99);
            r = '0;
            if (p < 65)      r[(m_phase + 1) % W] = 1'b1;
            else if (p < 75) r[m_phase] = 1'b1;
            else             r = W'($urandom_range(0, (1 << W) - 1));
            step("rand", r, ($urandom_range(0, 19) == 0));
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
